// File: rtl/gcd_pkg.sv
// Shared types for the parametrised GCD unit: control states and request layout.
package gcd_pkg;

  localparam int GCD_WIDTH     = 16;
  localparam int GCD_TAG_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_t;

  typedef struct packed {
    logic [GCD_WIDTH-1:0]     a;
    logic [GCD_WIDTH-1:0]     b;
    logic [GCD_TAG_WIDTH-1:0] tag;
  } gcd_req_t;

endpackage

// File: rtl/gcd_datapath.sv
// A/B/tag registers and step logic for the GCD unit.
// GCD_BINARY_EN selects binary (Stein) stepping; default is swap/subtract.
module gcd_datapath #(
  parameter int WIDTH     = 16,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  input  logic [TAG_WIDTH-1:0] tag_in,
  output logic [WIDTH-1:0]     result,
  output logic [TAG_WIDTH-1:0] tag,
  output logic                 done
);

  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 a_lt_b;
  logic [WIDTH-1:0]     diff_ab;

  assign a_lt_b  = a_q < b_q;
  assign diff_ab = a_q - b_q;

`ifdef GCD_BINARY_EN
  localparam int KW = $clog2(WIDTH);
  localparam logic [KW-1:0] K_ONE = 1;

  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] diff_ba;

  assign diff_ba = b_q - a_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      tag_q <= '0;
      k_q   <= '0;
    end else if (load) begin
      a_q   <= a_in;
      b_q   <= b_in;
      tag_q <= tag_in;
      k_q   <= '0;
    end else if (step) begin
      // B==0 means A holds the odd part; restore the shared power of two once.
      if (b_q == '0) begin
        a_q <= a_q << k_q;
        k_q <= '0;
      end else if (a_q == '0) begin
        a_q <= b_q;
        b_q <= '0;
      end else if (!a_q[0] && !b_q[0]) begin
        a_q <= a_q >> 1;
        b_q <= b_q >> 1;
        k_q <= k_q + K_ONE;
      end else if (!a_q[0]) begin
        a_q <= a_q >> 1;
      end else if (!b_q[0]) begin
        b_q <= b_q >> 1;
      end else if (!a_lt_b) begin
        a_q <= diff_ab >> 1;
      end else begin
        b_q <= diff_ba >> 1;
      end
    end
  end

  assign done = (b_q == '0) && (k_q == '0);
`else
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      tag_q <= '0;
    end else if (load) begin
      a_q   <= a_in;
      b_q   <= b_in;
      tag_q <= tag_in;
    end else if (step) begin
      if (a_lt_b) begin
        a_q <= b_q;
        b_q <= a_q;
      end else if (b_q != '0) begin
        a_q <= diff_ab;
      end
    end
  end

  assign done = (b_q == '0);
`endif

  assign result = a_q;
  assign tag    = tag_q;

endmodule

// File: rtl/gcd_unit_param.sv
// Parametrised GCD unit with val/rdy request/response, tag return and busy flag.
// Define GCD_BINARY_EN to build the binary (Stein) datapath.
//
// state | meaning
// IDLE  | ready for a request
// CALC  | datapath stepping, one step per cycle
// DONE  | result presented, held until resp_rdy
module gcd_unit_param
  import gcd_pkg::*;
#(
  parameter int WIDTH     = GCD_WIDTH,
  parameter int TAG_WIDTH = GCD_TAG_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_val,
  output logic                 req_rdy,
  input  logic [2*WIDTH-1:0]   req_msg,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic                 resp_val,
  input  logic                 resp_rdy,
  output logic [WIDTH-1:0]     resp_msg,
  output logic [TAG_WIDTH-1:0] resp_tag,
  output logic                 busy
);

  gcd_state_t           state;
  logic                 load;
  logic                 step;
  logic                 dp_done;
  logic [WIDTH-1:0]     dp_result;
  logic [TAG_WIDTH-1:0] dp_tag;

  assign load = (state == IDLE) && req_val;
  assign step = (state == CALC) && !dp_done;

  gcd_datapath #(
    .WIDTH     (WIDTH),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_datapath (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .step    (step),
    .a_in    (req_msg[2*WIDTH-1:WIDTH]),
    .b_in    (req_msg[WIDTH-1:0]),
    .tag_in  (req_tag),
    .result  (dp_result),
    .tag     (dp_tag),
    .done    (dp_done)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      req_rdy  <= 1'b1;
      resp_val <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_val) begin
            state   <= CALC;
            req_rdy <= 1'b0;
            busy    <= 1'b1;
          end
        end
        CALC: begin
          if (dp_done) begin
            state    <= DONE;
            resp_val <= 1'b1;
          end
        end
        DONE: begin
          // Return to IDLE only; a new request can be taken no earlier than next cycle.
          if (resp_rdy) begin
            state    <= IDLE;
            resp_val <= 1'b0;
            busy     <= 1'b0;
            req_rdy  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          req_rdy  <= 1'b1;
          resp_val <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  assign resp_msg = resp_val ? dp_result : '0;
  assign resp_tag = resp_val ? dp_tag : '0;

endmodule

// File: tb/tb_gcd_unit_param.sv
// Directed and random bench for gcd_unit_param at WIDTH=16 (scoreboarded) and WIDTH=32.
module tb_gcd_unit_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        req_val, req_rdy, resp_val, resp_rdy, busy;
  logic [31:0] req_msg;
  logic [3:0]  req_tag, resp_tag;
  logic [15:0] resp_msg;

  logic        w_req_val, w_req_rdy, w_resp_val, w_resp_rdy, w_busy;
  logic [63:0] w_req_msg;
  logic [3:0]  w_req_tag, w_resp_tag;
  logic [31:0] w_resp_msg;

  gcd_unit_param #(.WIDTH(16), .TAG_WIDTH(4)) dut16 (
    .clk(clk), .reset_n(reset_n),
    .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg), .req_tag(req_tag),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg), .resp_tag(resp_tag),
    .busy(busy)
  );

  gcd_unit_param #(.WIDTH(32), .TAG_WIDTH(4)) dut32 (
    .clk(clk), .reset_n(reset_n),
    .req_val(w_req_val), .req_rdy(w_req_rdy), .req_msg(w_req_msg), .req_tag(w_req_tag),
    .resp_val(w_resp_val), .resp_rdy(w_resp_rdy), .resp_msg(w_resp_msg), .resp_tag(w_resp_tag),
    .busy(w_busy)
  );

  typedef struct {
    logic [15:0] res;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  bit   rand_rdy = 1'b0;

  function automatic logic [63:0] gcd_ref(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; a response that fires on the
  // coming edge is checked against the scoreboard just before it.
  task automatic tick();
    exp_t e;
    if (reset_n && resp_val && resp_rdy) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("resp_msg", 64'(resp_msg), 64'(e.res));
        chk("resp_tag", 64'(resp_tag), 64'(e.tag));
      end
    end
    @(posedge clk);
    #1;
    if (rand_rdy) resp_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag,
                        input bit expect_resp);
    int g;
    exp_t e;
    g = 0;
    while (!req_rdy && g < 1000) begin
      tick();
      g++;
    end
    chk("req_rdy_wait", 64'(g < 1000), 64'd1);
    req_msg = {a, b};
    req_tag = tag;
    req_val = 1'b1;
    if (expect_resp) begin
      e.res = 16'(gcd_ref(64'(a), 64'(b)));
      e.tag = tag;
      sb.push_back(e);
    end
    tick();
    req_val = 1'b0;
  endtask

  task automatic wait_idle16();
    int g;
    g = 0;
    while (busy && g < 1000) begin
      tick();
      g++;
    end
    chk("idle_wait", 64'(g < 1000), 64'd1);
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    int g;
    chk("w_req_rdy", 64'(w_req_rdy), 64'd1);
    w_req_msg = {a, b};
    w_req_tag = tag;
    w_req_val = 1'b1;
    tick();
    w_req_val = 1'b0;
    g = 0;
    while (!w_resp_val && g < 40000) begin
      tick();
      g++;
    end
    chk("w_resp_wait", 64'(g < 40000), 64'd1);
    chk("w_resp_msg", 64'(w_resp_msg), gcd_ref(64'(a), 64'(b)));
    chk("w_resp_tag", 64'(w_resp_tag), 64'(tag));
    tick();
    chk("w_resp_drop", 64'(w_resp_val), 64'd0);
  endtask

  initial begin
    int cyc;
    int g;
    int seen;
    logic [15:0] gm, xm, ym;

    reset_n = 1'b0;
    req_val = 1'b0; req_msg = '0; req_tag = '0; resp_rdy = 1'b0;
    w_req_val = 1'b0; w_req_msg = '0; w_req_tag = '0; w_resp_rdy = 1'b1;
    tick();
    tick();
    chk("rst_req_rdy", 64'(req_rdy), 64'd1);
    chk("rst_resp_val", 64'(resp_val), 64'd0);
    chk("rst_resp_msg", 64'(resp_msg), 64'd0);
    chk("rst_resp_tag", 64'(resp_tag), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    resp_rdy = 1'b1;
    tick();

    // basic (15,5) tag 3: latency measured in cycles after the accept edge
    req_msg = {16'd15, 16'd5};
    req_tag = 4'd3;
    req_val = 1'b1;
    sb.push_back('{res: 16'd5, tag: 4'd3});
    tick();
    req_val = 1'b0;
    cyc = 1;
    while (!resp_val && cyc < 100) begin
      tick();
      cyc++;
    end
`ifdef GCD_BINARY_EN
    chk("basic_latency_bound", 64'(cyc <= 2*16+3), 64'd1);
`else
    chk("basic_latency", 64'(cyc), 64'd6);
`endif
    chk("basic_busy", 64'(busy), 64'd1);
    chk("basic_req_rdy_done", 64'(req_rdy), 64'd0);
    tick();
    chk("basic_pulse", 64'(resp_val), 64'd0);
    chk("basic_req_rdy_after", 64'(req_rdy), 64'd1);

    // zero operands
    send16(16'd0, 16'd7, 4'd1, 1'b1);
    wait_idle16();
    send16(16'd9, 16'd0, 4'd2, 1'b1);
    wait_idle16();
    send16(16'd0, 16'd0, 4'd4, 1'b1);
    wait_idle16();

    // back-pressure: (36,24) -> 12, held for 10 cycles
    resp_rdy = 1'b0;
    send16(16'd36, 16'd24, 4'd5, 1'b1);
    g = 0;
    while (!resp_val && g < 1000) begin
      tick();
      g++;
    end
    chk("bp_resp_wait", 64'(g < 1000), 64'd1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_val", 64'(resp_val), 64'd1);
      chk("bp_msg", 64'(resp_msg), 64'd12);
      chk("bp_tag", 64'(resp_tag), 64'd5);
      chk("bp_req_rdy", 64'(req_rdy), 64'd0);
      chk("bp_busy", 64'(busy), 64'd1);
      tick();
    end
    resp_rdy = 1'b1;
    tick();
    chk("bp_release_rdy", 64'(req_rdy), 64'd1);
    chk("bp_release_busy", 64'(busy), 64'd0);
    chk("bp_release_val", 64'(resp_val), 64'd0);
    chk("bp_release_msg", 64'(resp_msg), 64'd0);

    // reset during CALC of (48,18) drops that request
    send16(16'd48, 16'd18, 4'd7, 1'b0);
    tick();
    chk("mid_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mid_rst_req_rdy", 64'(req_rdy), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (resp_val) seen++;
    end
    chk("mid_rst_no_resp", 64'(seen), 64'd0);
    send16(16'd48, 16'd18, 4'd9, 1'b1);
    wait_idle16();

    // wide datapath
    send32(32'hFFFF_FFFE, 32'h7FFF_FFFF, 4'd1);
    send32(32'h8000_0000, 32'h0001_0000, 4'd2);
`ifdef GCD_BINARY_EN
    send32(32'hFFFF_FFFE, 32'h0000_0006, 4'd3);
`endif

    // random stream with random resp_rdy stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      gm = 16'($urandom_range(1, 2000));
      xm = 16'($urandom_range(0, 30));
      ym = 16'($urandom_range(0, 30));
      send16(16'(xm * gm), 16'(ym * gm), 4'(i), 1'b1);
    end
    g = 0;
    while (sb.size() != 0 && g < 5000) begin
      tick();
      g++;
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);
    rand_rdy = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
